// File: rtl/fp_dispatch_credit_ctrl.sv
// FPU issue dispatch with per-unit in-flight credits and merged writeback fflags.
// Optional stall counter: define FP_DISPATCH_PERF_EN to build perf_stall_count.

module fp_dispatch_credit_unit #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic unit_ready_i,
  input  logic acc_i,
  input  logic cmp_i,
  output logic ready_o,
  output logic nz_d_o,
  output logic underflow_o
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec;

  assign ready_o     = unit_ready_i & (cnt_q < MAX_C);
  assign underflow_o = cmp_i & (cnt_q == '0);
  assign dec         = cmp_i & (cnt_q != '0);

  // acc_i only fires while ready, so the increment can never pass MAX_C
  always_comb begin
    cnt_d = cnt_q;
    if (acc_i & ~dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (dec & ~acc_i) cnt_d = cnt_q - CNT_W'(1);
  end

  assign nz_d_o = |cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

module fp_dispatch_credit_ctrl #(
  parameter int NUM_UNITS    = 5,
  parameter int ID_W         = 3,
  parameter int MAX_INFLIGHT = 4,
  parameter int NUM_WB       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_new_request,
  input  logic [NUM_UNITS-1:0]  issue_unit,
  input  logic [ID_W-1:0]       issue_id,
  output logic [NUM_UNITS-1:0]  issue_ready,
  input  logic [NUM_UNITS-1:0]  unit_ready,
  output logic [NUM_UNITS-1:0]  unit_new_request,
  output logic [ID_W-1:0]       unit_id,
  input  logic [NUM_UNITS-1:0]  unit_complete,
  input  logic [NUM_WB-1:0]     wb_done,
  input  logic [NUM_WB-1:0]     wb_ack,
  input  logic [5*NUM_WB-1:0]   wb_fflags,
  output logic [4:0]            fflags,
  output logic                  fflags_valid,
  output logic                  busy,
  output logic                  protocol_error,
  output logic [31:0]           perf_stall_count
);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  typedef struct packed {
    logic [NUM_UNITS-1:0] req;
    logic [ID_W-1:0]      id;
  } disp_t;

  logic                 issue_onehot, accept, bad_issue;
  logic [NUM_UNITS-1:0] acc_u, nz_d, underflow;
  logic [NUM_WB-1:0]    wb_acc;
  logic [4:0]           merged;

  disp_t      disp_q, disp_d;
  logic [4:0] fflags_q;
  logic       fflags_valid_q, busy_q, err_q, err_d;

  assign issue_onehot = $onehot(issue_unit);
  assign accept       = issue_new_request & issue_onehot & |(issue_unit & issue_ready);
  assign bad_issue    = issue_new_request & ~issue_onehot;
  assign acc_u        = accept ? issue_unit : '0;

  fp_dispatch_credit_unit #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_cred [NUM_UNITS-1:0] (
    .clk          (clk),
    .rst          (rst),
    .unit_ready_i (unit_ready),
    .acc_i        (acc_u),
    .cmp_i        (unit_complete),
    .ready_o      (issue_ready),
    .nz_d_o       (nz_d),
    .underflow_o  (underflow)
  );

  assign wb_acc = wb_done & wb_ack;

  always_comb begin
    merged = '0;
    for (int k = 0; k < NUM_WB; k++)
      merged = merged | (wb_fflags[5*k +: 5] & {5{wb_acc[k]}});
  end

  // unit_id holds across idle cycles; only the strobe returns to zero
  always_comb begin
    disp_d     = disp_q;
    disp_d.req = '0;
    if (accept) begin
      disp_d.req = issue_unit;
      disp_d.id  = issue_id;
    end
  end

  assign err_d = err_q | bad_issue | (|underflow);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q         <= '0;
      fflags_q       <= '0;
      fflags_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      disp_q         <= disp_d;
      fflags_q       <= merged;
      fflags_valid_q <= |wb_acc;
      busy_q         <= |nz_d;
      err_q          <= err_d;
    end
  end

  assign unit_new_request = disp_q.req;
  assign unit_id          = disp_q.id;
  assign fflags           = fflags_q;
  assign fflags_valid     = fflags_valid_q;
  assign busy             = busy_q;
  assign protocol_error   = err_q;

`ifdef FP_DISPATCH_PERF_EN
  logic        stall;
  logic [31:0] perf_q;

  assign stall = issue_new_request & issue_onehot & ~|(issue_unit & issue_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             perf_q <= '0;
    else if (stall && perf_q != '1)      perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_count = perf_q;
`else
  assign perf_stall_count = '0;
`endif
endmodule

// File: tb/tb_fp_dispatch_credit_ctrl.sv
// Directed bench for fp_dispatch_credit_ctrl with an integer-level credit/flags model.
module tb_fp_dispatch_credit_ctrl;
  localparam int NU = 5, IW = 3, MX = 4, NW = 2;

  logic          clk = 1'b0, rst = 1'b0;
  logic          issue_new_request = 1'b0;
  logic [NU-1:0] issue_unit = '0;
  logic [IW-1:0] issue_id = '0;
  logic [NU-1:0] issue_ready;
  logic [NU-1:0] unit_ready = '1;
  logic [NU-1:0] unit_new_request;
  logic [IW-1:0] unit_id;
  logic [NU-1:0] unit_complete = '0;
  logic [NW-1:0] wb_done = '0, wb_ack = '0;
  logic [5*NW-1:0] wb_fflags = '0;
  logic [4:0]    fflags;
  logic          fflags_valid, busy, protocol_error;
  logic [31:0]   perf_stall_count;

  int n_chk = 0, n_err = 0;

  fp_dispatch_credit_ctrl #(.NUM_UNITS(NU), .ID_W(IW), .MAX_INFLIGHT(MX), .NUM_WB(NW)) dut (
    .clk(clk), .rst(rst),
    .issue_new_request(issue_new_request), .issue_unit(issue_unit), .issue_id(issue_id),
    .issue_ready(issue_ready), .unit_ready(unit_ready),
    .unit_new_request(unit_new_request), .unit_id(unit_id),
    .unit_complete(unit_complete),
    .wb_done(wb_done), .wb_ack(wb_ack), .wb_fflags(wb_fflags),
    .fflags(fflags), .fflags_valid(fflags_valid), .busy(busy),
    .protocol_error(protocol_error), .perf_stall_count(perf_stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: outstanding ops per unit as plain integers
  int            m_cnt[NU];
  logic [NU-1:0] e_req = '0;
  logic [IW-1:0] e_id = '0;
  logic [4:0]    e_ff = '0;
  logic          e_fv = 1'b0, e_busy = 1'b0, e_err = 1'b0;
  logic [31:0]   e_perf = '0;

  function automatic logic [NU-1:0] m_ready();
    logic [NU-1:0] r;
    for (int u = 0; u < NU; u++) r[u] = unit_ready[u] && (m_cnt[u] < MX);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NU; u++) m_cnt[u] = 0;
      e_req = '0; e_id = '0; e_ff = '0; e_fv = 0; e_busy = 0; e_err = 0; e_perf = '0;
    end else begin
      logic [NU-1:0] rdy;
      logic one, acc;
      rdy = m_ready();
      one = ($countones(issue_unit) == 1);
      acc = issue_new_request && one && ((issue_unit & rdy) != 0);
      if (issue_new_request && !one) e_err = 1;
      if (issue_new_request && one && !acc && e_perf != 32'hFFFFFFFF) e_perf = e_perf + 1;
      for (int u = 0; u < NU; u++) begin
        if (unit_complete[u]) begin
          if (m_cnt[u] == 0) e_err = 1;
          else m_cnt[u]--;
        end
        if (acc && issue_unit[u]) m_cnt[u]++;
      end
      e_req = acc ? issue_unit : '0;
      if (acc) e_id = issue_id;
      e_ff = '0; e_fv = 0;
      for (int k = 0; k < NW; k++)
        if (wb_done[k] && wb_ack[k]) begin
          e_ff = e_ff | wb_fflags[5*k +: 5];
          e_fv = 1;
        end
      e_busy = 0;
      for (int u = 0; u < NU; u++) if (m_cnt[u] > 0) e_busy = 1;
    end
  end

  always @(negedge clk) begin
    chk("issue_ready", issue_ready, m_ready());
    chk("unit_new_request", unit_new_request, e_req);
    chk("unit_id", unit_id, e_id);
    chk("fflags", fflags, e_ff);
    chk("fflags_valid", fflags_valid, e_fv);
    chk("busy", busy, e_busy);
    chk("protocol_error", protocol_error, e_err);
`ifdef FP_DISPATCH_PERF_EN
    chk("perf_stall_count", perf_stall_count, e_perf);
`else
    chk("perf_stall_count", perf_stall_count, 32'd0);
`endif
  end

  task automatic step(input logic req, input logic [NU-1:0] un, input logic [IW-1:0] id,
                      input logic [NU-1:0] cmp);
    issue_new_request = req; issue_unit = un; issue_id = id; unit_complete = cmp;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst unit_new_request", unit_new_request, 5'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst protocol_error", protocol_error, 1'b0);
    chk("rst issue_ready", issue_ready, 5'b11111);
    #1 rst = 1'b0;

    // fill unit 2 to its credit limit
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 5'b00100, IW'(i), '0);
      chk("fill req", unit_new_request, 5'b00100);
      chk("fill id", unit_id, 64'(i));
    end
    chk("full ready2", issue_ready[2], 1'b0);
    chk("full busy", busy, 1'b1);
    step(1'b1, 5'b00100, 3'd5, '0);
    chk("drop5 req", unit_new_request, 5'b0);
    chk("drop5 id hold", unit_id, 3'd4);

    // complete and issue together while full: issue still rejected
    step(1'b1, 5'b00100, 3'd5, 5'b00100);
    chk("cmp+iss req", unit_new_request, 5'b0);
    chk("cmp ready2", issue_ready[2], 1'b1);
    step(1'b1, 5'b00100, 3'd6, '0);
    chk("refill req", unit_new_request, 5'b00100);
    chk("refill id", unit_id, 3'd6);
    chk("refill ready2", issue_ready[2], 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 5'b00100);
    chk("drained busy", busy, 1'b0);

    // non-one-hot issue, then completion on an empty unit
    step(1'b1, 5'b00110, 3'd1, '0);
    chk("bad req", unit_new_request, 5'b0);
    chk("bad err", protocol_error, 1'b1);
    idle(); idle();
    chk("err sticky", protocol_error, 1'b1);
    step(1'b0, '0, '0, 5'b00001);
    idle();
    chk("uf busy", busy, 1'b0);

    // writeback flag merge
    wb_fflags = {5'b10000, 5'b00001}; wb_done = 2'b11; wb_ack = 2'b11;
    idle();
    chk("ff both", fflags, 5'b10001);
    chk("ffv both", fflags_valid, 1'b1);
    wb_ack = 2'b01;
    idle();
    chk("ff p0", fflags, 5'b00001);
    wb_done = 2'b10; wb_ack = 2'b01;
    idle();
    chk("ffv none", fflags_valid, 1'b0);
    chk("ff none", fflags, 5'b0);
    wb_done = '0; wb_ack = '0; wb_fflags = '0;

    // back-to-back issues across units
    step(1'b1, 5'b10000, 3'd2, '0);
    step(1'b1, 5'b00010, 3'd3, 5'b10000);
    chk("b2b id", unit_id, 3'd3);

    // three ops on unit 0, then async reset mid-flight
    step(1'b1, 5'b00001, 3'd1, 5'b00010);
    step(1'b1, 5'b00001, 3'd2, '0);
    step(1'b1, 5'b00001, 3'd7, '0);
    #2 rst = 1'b1;
    #1;
    chk("arst req", unit_new_request, 5'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst err", protocol_error, 1'b0);
    chk("arst id", unit_id, 3'd0);
    #3 rst = 1'b0;
    step(1'b0, '0, '0, '0);
    chk("post-rst ready0", issue_ready[0], 1'b1);
    step(1'b0, '0, '0, 5'b00001);
    chk("post-rst cmp err", protocol_error, 1'b1);

    // stall counter: unit 1 not ready for 7 cycles
    unit_ready = 5'b11101;
    for (int i = 0; i < 7; i++) step(1'b1, 5'b00010, 3'd4, '0);
    step(1'b0, '0, '0, '0);
`ifdef FP_DISPATCH_PERF_EN
    chk("perf 7", perf_stall_count, 32'd7);
`else
    chk("perf off", perf_stall_count, 32'd0);
`endif
    chk("stall no req", unit_new_request, 5'b0);
    unit_ready = '1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
